sprite_rom_arbiter: RTL and testbench

//  Shares one sprite ROM read port (addr + sprite type -> 1-bit colour) among NUM_REQ sprite renderers.

---
 rtl/sprite_arb_pkg.sv | 26 ++
 rtl/sprite_rom_arbiter_rr_pick.sv | 31 +++
 rtl/sprite_rom_arbiter.sv | 125 ++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_arb_pkg.sv
// Shared constants and helpers for the sprite ROM arbiter.
// Requester indices name the renderers that share the ROM.
package sprite_arb_pkg;

  localparam int REQ_DINO = 0;
  localparam int REQ_OBS1 = 1;
  localparam int REQ_OBS2 = 2;
  localparam int REQ_BG   = 3;

  localparam int NUM_REQ_DEF = 4;
  localparam int ADDR_W_DEF  = 8;
  localparam int TYPE_W_DEF  = 3;
  localparam int ROM_LAT_DEF = 1;
  localparam int MAX_REQ     = 8;

  // Index of the set bit; the input is assumed one-hot (or zero, giving 0).
  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or above ptr wins,
// wrapping around; done by rotating the request vector and priority-encoding it.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic             any
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;

  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    gnt_rot = '0;
    // Descending scan so the lowest rotated index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) gnt_rot = N'(1) << i;
    end
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    gnt_oh  = gnt_dbl[2*N-1:N];
    any     = |req;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port among the renderers.
// Optional SPRITE_ARB_PLAYER_PRIO_EN: requester 0 (dino) gets absolute priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TYPE_W  = TYPE_W_DEF,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*TYPE_W-1:0] i_type,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_rom_en,
  output logic [ADDR_W-1:0]         o_rom_addr,
  output logic [TYPE_W-1:0]         o_rom_type,
  input  logic                      i_rom_data,
  output logic [NUM_REQ-1:0]        o_valid,
  output logic [NUM_REQ-1:0]        o_sprite_color
);

  localparam int PTR_W = $clog2(NUM_REQ);
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
  localparam int PTR_INIT = 1;
`else
  localparam int PTR_INIT = 0;
`endif

  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] rr_req;
  logic [NUM_REQ-1:0] rr_oh;
  logic               rr_any;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_any;
  logic               advance;
  logic [2:0]         win_idx;
  logic [3:0]         nxt_wide;

  // A requester granted this cycle is still holding i_req; mask it out.
  assign eligible = i_req & ~o_gnt;

`ifdef SPRITE_ARB_PLAYER_PRIO_EN
  assign rr_req  = eligible & ~NUM_REQ'(1);
  assign win_oh  = eligible[0] ? NUM_REQ'(1) : rr_oh;
  assign win_any = eligible[0] | rr_any;
  assign advance = rr_any & ~eligible[0];
`else
  assign rr_req  = eligible;
  assign win_oh  = rr_oh;
  assign win_any = rr_any;
  assign advance = rr_any;
`endif

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (rr_req),
    .ptr    (ptr),
    .gnt_oh (rr_oh),
    .any    (rr_any)
  );

  always_comb begin
    win_idx  = onehot2idx(MAX_REQ'(win_oh));
    nxt_wide = 4'(win_idx) + 4'd1;
    if (int'(nxt_wide) >= NUM_REQ) ptr_nxt = PTR_W'(PTR_INIT);
    else                           ptr_nxt = PTR_W'(nxt_wide);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= PTR_W'(PTR_INIT);
      o_gnt      <= '0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
      o_rom_type <= '0;
    end else begin
      o_gnt    <= win_oh;
      o_rom_en <= win_any;
      if (win_any) begin
        o_rom_addr <= i_addr[int'(win_idx)*ADDR_W +: ADDR_W];
        o_rom_type <= i_type[int'(win_idx)*TYPE_W +: TYPE_W];
      end
      if (advance) ptr <= ptr_nxt;
    end
  end

  // Response tracking: the grant's one-hot id rides alongside the ROM latency.
  logic [ROM_LAT-1:0]              pipe_vld;
  logic [ROM_LAT-1:0][NUM_REQ-1:0] pipe_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= o_rom_en;
      pipe_id[0]  <= o_gnt;
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_id[k]  <= pipe_id[k-1];
      end
    end
  end

  // Gated by rst so a response landing in a reset cycle is never announced.
  assign o_valid = (pipe_vld[ROM_LAT-1] && !rst) ? pipe_id[ROM_LAT-1] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_sprite_color <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (o_valid[k]) o_sprite_color[k] <= i_rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Scoreboard bench for sprite_rom_arbiter (ROM_LAT=1); honours SPRITE_ARB_PLAYER_PRIO_EN
// in its reference model when the macro is defined.
module tb_sprite_rom_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int TW = 3;
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
  localparam int PINIT = 1;
`else
  localparam int PINIT = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    i_req = '0;
  logic [N*AW-1:0] i_addr = '0;
  logic [N*TW-1:0] i_type = '0;
  logic [N-1:0]    o_gnt;
  logic            o_rom_en;
  logic [AW-1:0]   o_rom_addr;
  logic [TW-1:0]   o_rom_type;
  logic            i_rom_data = 1'b0;
  logic [N-1:0]    o_valid;
  logic [N-1:0]    o_sprite_color;

  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TYPE_W(TW), .ROM_LAT(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_type         (i_type),
    .o_gnt          (o_gnt),
    .o_rom_en       (o_rom_en),
    .o_rom_addr     (o_rom_addr),
    .o_rom_type     (o_rom_type),
    .i_rom_data     (i_rom_data),
    .o_valid        (o_valid),
    .o_sprite_color (o_sprite_color)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rom_fn(input logic [AW-1:0] a, input logic [TW-1:0] t);
    return ^(a ^ {5'b0, t});
  endfunction

  typedef struct {
    int   due;
    int   id;
    logic data;
  } exp_t;

  exp_t          q[$];
  int            cyc = 0;
  int            m_ptr = PINIT;
  logic [N-1:0]  m_gnt = '0;
  logic [N-1:0]  m_color = '0;
  logic [AW-1:0] m_addr = '0;
  logic [TW-1:0] m_type = '0;

  // ROM with one cycle of read latency
  initial forever begin
    @(posedge clk);
    i_rom_data <= (o_rom_en === 1'b1) ? rom_fn(o_rom_addr, o_rom_type) : 1'b0;
  end

  // Reference model, advanced on each rising edge from the inputs of the ending cycle
  initial forever begin
    logic [N-1:0] elig;
    int           win;
    @(posedge clk);
    if (rst) begin
      m_gnt   = '0;
      m_ptr   = PINIT;
      m_color = '0;
      m_addr  = '0;
      m_type  = '0;
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        m_color[q[0].id] = q[0].data;
        void'(q.pop_front());
      end
      elig = i_req & ~m_gnt;
      win  = -1;
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
      if (elig[0]) win = 0;
      else for (int s = 0; s < N; s++) begin
        int c;
        c = (m_ptr + s) % N;
        if (c != 0 && elig[c] && win < 0) win = c;
      end
`else
      for (int s = 0; s < N; s++) begin
        int c;
        c = (m_ptr + s) % N;
        if (elig[c] && win < 0) win = c;
      end
`endif
      m_gnt = '0;
      if (win >= 0) begin
        m_gnt[win] = 1'b1;
        m_addr = i_addr[win*AW +: AW];
        m_type = i_type[win*TW +: TW];
        q.push_back('{due: cyc + 2, id: win, data: rom_fn(m_addr, m_type)});
`ifdef SPRITE_ARB_PLAYER_PRIO_EN
        if (win != 0) m_ptr = ((win + 1) % N == 0) ? 1 : (win + 1) % N;
`else
        m_ptr = (win + 1) % N;
`endif
      end
    end
    cyc++;
  end

  // Per-cycle output comparison, mid-cycle
  initial forever begin
    logic [N-1:0] exp_v;
    @(negedge clk);
    exp_v = '0;
    if (!rst && q.size() > 0 && q[0].due == cyc) exp_v[q[0].id] = 1'b1;
    chk("gnt",      32'(o_gnt),          32'(m_gnt));
    chk("rom_en",   32'(o_rom_en),       32'(|m_gnt));
    chk("rom_addr", 32'(o_rom_addr),     32'(m_addr));
    chk("rom_type", 32'(o_rom_type),     32'(m_type));
    chk("valid",    32'(o_valid),        32'(exp_v));
    chk("color",    32'(o_sprite_color), 32'(m_color));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [N-1:0] prev_col;
    logic         seen_v1;

    i_req  = '1;
    i_addr = 32'($urandom());
    i_type = 12'($urandom());
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt",   32'(o_gnt),          32'h0);
    chk("rst_color", 32'(o_sprite_color), 32'h0);
    @(negedge clk);
    chk("first_gnt", 32'(o_gnt), 32'h1);
    repeat (8) tick();

    i_req = '0;
    repeat (4) tick();

    // single requester 2 with a known address/type
    prev_col      = o_sprite_color;
    i_addr[16+:8] = 8'h5A;
    i_type[6+:3]  = 3'd4;
    i_req         = 4'b0100;
    tick();
    i_req = '0;
    @(negedge clk);
    chk("single_addr", 32'(o_rom_addr), 32'h5A);
    chk("single_type", 32'(o_rom_type), 32'd4);
    tick();
    tick();
    @(negedge clk);
    chk("single_col",  32'(o_sprite_color[2]),               32'd1);
    chk("single_keep", 32'(o_sprite_color & 4'b1011), 32'(prev_col & 4'b1011));

    // requester 1 withdraws while requester 0 wins
    tick();
    i_req = 4'b0011;
    tick();
    i_req   = '0;
    seen_v1 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_v1 |= o_valid[1];
    end
    chk("withdraw_v1", 32'(seen_v1), 32'd0);

    // make sure some colour bits are set before the mid-flight reset
    tick();
    i_addr = {8'h01, 8'h03, 8'h07, 8'h01};
    i_type = '0;
    i_req  = '1;
    repeat (6) tick();
    i_req = 4'b1000;
    i_addr[24+:8] = 8'h01;
    tick();
    i_req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_col",   32'(o_sprite_color), 32'h0);
    chk("mid_rst_valid", 32'(o_valid),        32'h0);

    tick();
    i_addr = 32'($urandom());
    i_type = 12'($urandom());
    i_req  = '1;
    repeat (6) tick();
    i_req = 4'b1110;
    repeat (6) tick();

    repeat (300) begin
      i_req  = 4'($urandom());
      i_addr = 32'($urandom());
      i_type = 12'($urandom());
      tick();
    end
    i_req = '0;
    repeat (5) tick();
    chk("q_drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
